// File: rtl/cycle_measure_mc.sv
// rtl/cycle_measure_mc.sv - multi-channel period/high-time measurement, Avalon-MM slave
// Each channel counts clk cycles over N input periods and latches PERIOD/HIGH results.
module cycle_measure_mc #(
    parameter int CH_NUM      = 4,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int ADDR_W      = $clog2(CH_NUM) + 2
) (
    input  logic              clk,
    input  logic              csi_reset_n,
    input  logic              avs_chipselect,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    input  logic [CH_NUM-1:0] coe_s_in
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_MEAS = 2'd2;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    // Synchroniser chain plus one delay register for edge detection
    logic [CH_NUM-1:0] sync_q [SYNC_STAGES];
    logic [CH_NUM-1:0] sync_d [SYNC_STAGES];
    logic [CH_NUM-1:0] lvl_q;
    logic [CH_NUM-1:0] lvl_d;
    logic [CH_NUM-1:0] sync_lvl;

    always_comb begin
        sync_d[0] = coe_s_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    assign lvl_d    = sync_lvl;

    always_ff @(posedge clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            lvl_q <= '0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            lvl_q <= lvl_d;
        end
    end

    logic [ADDR_W-1:0] addr_ch;
    logic [1:0]        addr_reg;
    logic [7:0]        wr_n;
    logic [CH_NUM-1:0] rd_period;
    logic [CH_NUM-1:0] rd_status;
    logic [CH_NUM-1:0] wr_ctrl;
    logic [31:0]       period_w [CH_NUM];
    logic [31:0]       high_w   [CH_NUM];
    logic [31:0]       status_w [CH_NUM];
    logic [31:0]       ctrl_w   [CH_NUM];
    logic [31:0]       rdata_q;
    logic [31:0]       rdata_d;

    assign addr_ch  = avs_address >> 2;
    assign addr_reg = avs_address[1:0];
    assign wr_n     = (avs_writedata[15:8] == 8'd0) ? 8'd1 : avs_writedata[15:8];

    // Channel indices with no channel behind them simply never match
    always_comb begin
        rdata_d   = '0;
        rd_period = '0;
        rd_status = '0;
        wr_ctrl   = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (addr_ch == ADDR_W'(i)) begin
                if (avs_chipselect && avs_read) begin
                    case (addr_reg)
                        2'd0: begin
                            rdata_d      = period_w[i];
                            rd_period[i] = 1'b1;
                        end
                        2'd1: rdata_d = high_w[i];
                        2'd2: begin
                            rdata_d      = status_w[i];
                            rd_status[i] = 1'b1;
                        end
                        default: rdata_d = ctrl_w[i];
                    endcase
                end
                if (avs_chipselect && avs_write && (addr_reg == 2'd3)) begin
                    wr_ctrl[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        logic [1:0]       state_q,  state_d;
        logic [CNT_W-1:0] cnt_q,    cnt_d;
        logic [CNT_W-1:0] hi_q,     hi_d;
        logic [CNT_W-1:0] idle_q,   idle_d;
        logic [CNT_W-1:0] period_q, period_d;
        logic [CNT_W-1:0] high_q,   high_d;
        logic [7:0]       edges_q,  edges_d;
        logic [7:0]       n_q,      n_d;
        logic             en_q,     en_d;
        logic             valid_q,  valid_d;
        logic             tout_q,   tout_d;
        logic             lvl;
        logic             rise;

        assign lvl  = sync_lvl[g];
        assign rise = sync_lvl[g] & ~lvl_q[g];

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            hi_d     = hi_q;
            idle_d   = idle_q;
            period_d = period_q;
            high_d   = high_q;
            edges_d  = edges_q;
            n_d      = n_q;
            en_d     = en_q;
            valid_d  = valid_q;
            tout_d   = tout_q;

            // Clearing reads come first so a same-cycle latch or timeout overrides them
            if (rd_period[g]) valid_d = 1'b0;
            if (rd_status[g]) tout_d  = 1'b0;

            case (state_q)
                S_IDLE: begin
                    cnt_d   = '0;
                    hi_d    = '0;
                    edges_d = '0;
                    idle_d  = '0;
                    if (en_q) state_d = S_ARM;
                end
                S_ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_W'(1);
                        hi_d    = CNT_W'(1);
                        edges_d = '0;
                        idle_d  = '0;
                        state_d = S_MEAS;
                    end else if (idle_q == TO_LAST) begin
                        tout_d   = 1'b1;
                        valid_d  = 1'b0;
                        period_d = '0;
                        high_d   = '0;
                        idle_d   = '0;
                    end else begin
                        idle_d = idle_q + CNT_W'(1);
                    end
                end
                S_MEAS: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    hi_d  = hi_q + CNT_W'(lvl);
                    if (rise) begin
                        idle_d = '0;
                        if ((edges_q + 8'd1) == n_q) begin
                            period_d = cnt_q;
                            high_d   = hi_q;
                            valid_d  = 1'b1;
                            tout_d   = 1'b0;
                            cnt_d    = CNT_W'(1);
                            hi_d     = CNT_W'(1);
                            edges_d  = '0;
                        end else begin
                            edges_d = edges_q + 8'd1;
                        end
                    end else if (idle_q == TO_LAST) begin
                        tout_d   = 1'b1;
                        valid_d  = 1'b0;
                        period_d = '0;
                        high_d   = '0;
                        cnt_d    = '0;
                        hi_d     = '0;
                        edges_d  = '0;
                        idle_d   = '0;
                        state_d  = S_ARM;
                    end else begin
                        idle_d = idle_q + CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // A CTRL write restarts the channel but keeps results and flags
            if (wr_ctrl[g]) begin
                en_d    = avs_writedata[0];
                n_d     = wr_n;
                cnt_d   = '0;
                hi_d    = '0;
                edges_d = '0;
                idle_d  = '0;
                state_d = avs_writedata[0] ? S_ARM : S_IDLE;
            end
        end

        always_ff @(posedge clk or negedge csi_reset_n) begin
            if (!csi_reset_n) begin
                state_q  <= S_IDLE;
                cnt_q    <= '0;
                hi_q     <= '0;
                idle_q   <= '0;
                period_q <= '0;
                high_q   <= '0;
                edges_q  <= '0;
                n_q      <= 8'd1;
                en_q     <= 1'b0;
                valid_q  <= 1'b0;
                tout_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                hi_q     <= hi_d;
                idle_q   <= idle_d;
                period_q <= period_d;
                high_q   <= high_d;
                edges_q  <= edges_d;
                n_q      <= n_d;
                en_q     <= en_d;
                valid_q  <= valid_d;
                tout_q   <= tout_d;
            end
        end

        assign period_w[g] = 32'(period_q);
        assign high_w[g]   = 32'(high_q);
        assign status_w[g] = {27'd0, state_q, 1'b0, tout_q, valid_q};
        assign ctrl_w[g]   = {16'd0, n_q, 7'd0, en_q};
    end

endmodule
